// File: rtl/enc_pkt_scheduler_if.sv
// Requester-side byte streams and encoder-side symbol stream of the packet scheduler.
// master = scheduler, slave = requesters/encoder/observer side.
interface enc_pkt_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0][7:0]          req_data;
    logic [NUM_REQ-1:0]               req_last;
    logic [NUM_REQ-1:0]               req_ready;
    logic                             enc_pushin;
    logic [8:0]                       enc_datain;
    logic                             enc_startin;
    logic [$clog2(NUM_REQ)-1:0]       grant_id;
    logic                             busy;
    logic                             trunc_err;

    modport master (
        input  req_valid, req_data, req_last,
        output req_ready, enc_pushin, enc_datain, enc_startin, grant_id, busy, trunc_err
    );
    modport slave (
        output req_valid, req_data, req_last,
        input  req_ready, enc_pushin, enc_datain, enc_startin, grant_id, busy, trunc_err
    );
endinterface

// File: rtl/enc_pkt_scheduler.sv
// Round-robin packet scheduler feeding the 8b/10b encoder: K28.1 x4 preamble,
// payload (truncated at MAX_LEN), K28.5, then an idle gap for the encoder trailer.
module enc_pkt_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int MAX_LEN = 64,
    parameter int IPG     = 6
) (
    input  logic clk,
    input  logic reset_n,
    enc_pkt_scheduler_if.master bus
);
    localparam int          GW     = $clog2(NUM_REQ);
    localparam logic [8:0]  K281   = 9'h13C;
    localparam logic [8:0]  K285   = 9'h1BC;
    localparam logic [15:0] LAST_B = 16'(MAX_LEN - 1);
    localparam logic [15:0] LAST_G = 16'(IPG - 1);

    typedef enum logic [2:0] {IDLE, PRE, DATA, EOP, DROP, GAP} state_t;

    state_t        state;
    logic [GW-1:0] rr;
    logic [15:0]   cnt;
    logic          trunc;
    logic [GW-1:0] grant;

    // first valid requester at or above the rr pointer, wrapping
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [GW-1:0] p);
        int idx;
        rr_pick = p;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(p) + i) % NUM_REQ;
            if (v[idx]) rr_pick = GW'(idx);
        end
    endfunction

    logic [GW-1:0] pick, pick_nxt;
    logic          serve, acc, acc_last;
    logic [7:0]    acc_byte;

    assign pick     = rr_pick(bus.req_valid, rr);
    assign pick_nxt = GW'((int'(pick) + 1) % NUM_REQ);
    assign serve    = (state == DATA) || (state == DROP);
    assign acc      = serve && bus.req_valid[grant];
    assign acc_last = bus.req_last[grant];
    assign acc_byte = bus.req_data[grant];

    assign bus.req_ready = serve ? (NUM_REQ'(1) << grant) : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.grant_id  = grant;

    // enc_* are registered one cycle ahead of the state they belong to;
    // enc_datain is left untouched on non-push cycles so it holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            rr              <= '0;
            cnt             <= '0;
            trunc           <= 1'b0;
            grant           <= '0;
            bus.enc_pushin  <= 1'b0;
            bus.enc_datain  <= '0;
            bus.enc_startin <= 1'b0;
            bus.trunc_err   <= 1'b0;
        end else begin
            bus.enc_pushin  <= 1'b0;
            bus.enc_startin <= 1'b0;
            bus.trunc_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        grant           <= pick;
                        rr              <= pick_nxt;
                        cnt             <= '0;
                        trunc           <= 1'b0;
                        state           <= PRE;
                        bus.enc_pushin  <= 1'b1;
                        bus.enc_startin <= 1'b1;
                        bus.enc_datain  <= K281;
                    end
                end
                PRE: begin
                    if (cnt == 16'd3) begin
                        cnt   <= '0;
                        state <= DATA;
                    end else begin
                        cnt            <= cnt + 16'd1;
                        bus.enc_pushin <= 1'b1;
                        bus.enc_datain <= K281;
                    end
                end
                DATA: begin
                    if (acc) begin
                        bus.enc_pushin <= 1'b1;
                        bus.enc_datain <= {1'b0, acc_byte};
                        cnt            <= cnt + 16'd1;
                        if (acc_last) begin
                            state <= EOP;
                        end else if (cnt == LAST_B) begin
                            bus.trunc_err <= 1'b1;
                            trunc         <= 1'b1;
                            state         <= EOP;
                        end
                    end
                end
                EOP: begin
                    bus.enc_pushin <= 1'b1;
                    bus.enc_datain <= K285;
                    cnt            <= '0;
                    state          <= trunc ? DROP : GAP;
                end
                DROP: begin
                    if (acc && acc_last) begin
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt == LAST_G) state <= IDLE;
                    else               cnt   <= cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_enc_pkt_scheduler.sv
// Scoreboard bench: packet-level round-robin model builds the expected symbol stream,
// a negedge monitor pops and compares every encoder push.
module tb_enc_pkt_scheduler;
    localparam int NR  = 4;
    localparam int ML  = 4;
    localparam int IPG = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    enc_pkt_scheduler_if #(.NUM_REQ(NR)) bus();
    enc_pkt_scheduler #(.NUM_REQ(NR), .MAX_LEN(ML), .IPG(IPG)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    typedef struct {
        logic [8:0] sym;
        logic       start;
        logic       trunc;
        int         gid;
        logic       exact;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       me;
    logic [8:0] stim_q[NR][$];
    int         dpos[NR];
    logic       cv[NR], pend[NR], first[NR];
    int         checks = 0, errors = 0;
    bit         drv_en = 0, mon_en = 0;
    logic [8:0] last_sym = '0;
    int         idle_cnt = 0, cur_gid = 0, dcnt = 0, m_rr = 0;
    bit         have_eop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // packet-level model: round robin over requesters that still have packets queued
    task automatic build_exp();
        int pos[NR];
        int g, n;
        bit done, tr, no_exact;
        logic [8:0] b;
        exp_t e;
        for (int r = 0; r < NR; r++) pos[r] = 0;
        no_exact = 1;
        forever begin
            g = -1;
            for (int i = 0; i < NR; i++)
                if (g < 0 && pos[(m_rr + i) % NR] < stim_q[(m_rr + i) % NR].size()) g = (m_rr + i) % NR;
            if (g < 0) break;
            m_rr = (g + 1) % NR;
            for (int k = 0; k < 4; k++) begin
                e = '{9'h13C, k == 0, 1'b0, g, (k == 0) && !no_exact};
                exp_q.push_back(e);
            end
            n = 0; tr = 0; done = 0;
            while (!done) begin
                b = stim_q[g][pos[g]];
                pos[g]++;
                n++;
                if (n <= ML) begin
                    e = '{{1'b0, b[7:0]}, 1'b0, (n == ML) && !b[8], g, 1'b0};
                    exp_q.push_back(e);
                    if (n == ML && !b[8]) tr = 1;
                end
                done = b[8];
            end
            e = '{9'h1BC, 1'b0, 1'b0, g, 1'b0};
            exp_q.push_back(e);
            no_exact = tr;
        end
    endtask

    // requesters: first byte of a packet is held valid until taken, later bytes may bubble
    always @(negedge clk) begin
        for (int r = 0; r < NR; r++) begin
            if (!drv_en) begin
                bus.req_valid[r] = 1'b0;
                bus.req_data[r]  = 8'h00;
                bus.req_last[r]  = 1'b0;
            end else begin
                if (pend[r]) begin
                    first[r] = stim_q[r][dpos[r]][8];
                    dpos[r]++;
                    cv[r]   = 1'b0;
                    pend[r] = 1'b0;
                end
                if (dpos[r] < stim_q[r].size()) begin
                    if (!cv[r] && (first[r] || $urandom_range(0, 2) != 0)) cv[r] = 1'b1;
                end else cv[r] = 1'b0;
                bus.req_valid[r] = cv[r];
                if (cv[r]) begin
                    bus.req_data[r] = stim_q[r][dpos[r]][7:0];
                    bus.req_last[r] = stim_q[r][dpos[r]][8];
                end else begin
                    bus.req_data[r] = 8'($urandom);
                    bus.req_last[r] = 1'($urandom);
                end
                pend[r] = cv[r] && bus.req_ready[r];
            end
        end
    end

    always @(negedge clk) if (mon_en && reset_n) begin
        chk("ready_onehot", 32'($countones(bus.req_ready) <= 1), 32'd1);
        if (bus.req_ready != '0) chk("ready_gid", 32'(bus.req_ready), 32'd1 << cur_gid);
        if (bus.enc_pushin) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_push actual=%0h required=none at %0t", bus.enc_datain, $time);
            end else begin
                me = exp_q.pop_front();
                chk("sym", 32'(bus.enc_datain), 32'(me.sym));
                chk("startin", 32'(bus.enc_startin), 32'(me.start));
                chk("trunc_err", 32'(bus.trunc_err), 32'(me.trunc));
                if (me.start) begin
                    chk("grant_id", 32'(bus.grant_id), 32'(me.gid));
                    cur_gid = me.gid;
                    if (me.exact) chk("gap_exact", 32'(idle_cnt), 32'(IPG));
                    else if (have_eop) chk("gap_min", 32'(idle_cnt >= IPG), 32'd1);
                end
                if (me.sym == 9'h1BC) begin have_eop = 1; idle_cnt = 0; end
                if (!me.sym[8]) dcnt++;
                last_sym = me.sym;
            end
        end else begin
            chk("datain_hold", 32'(bus.enc_datain), 32'(last_sym));
            chk("idle_startin", 32'(bus.enc_startin), 32'd0);
            chk("idle_trunc", 32'(bus.trunc_err), 32'd0);
            idle_cnt++;
        end
    end

    task automatic start_drivers();
        for (int r = 0; r < NR; r++) begin
            dpos[r] = 0; cv[r] = 1'b0; pend[r] = 1'b0; first[r] = 1'b1;
        end
        build_exp();
        mon_en = 1;
        drv_en = 1;
    endtask

    function automatic bit all_consumed();
        all_consumed = 1;
        for (int r = 0; r < NR; r++)
            if (dpos[r] < stim_q[r].size() || pend[r]) all_consumed = 0;
    endfunction

    task automatic clear_stim();
        drv_en = 0;
        for (int r = 0; r < NR; r++) stim_q[r].delete();
        exp_q.delete();
    endtask

    task automatic run_phase(input string name);
        bit ok;
        ok = 0;
        start_drivers();
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            if (all_consumed() && exp_q.size() == 0 && !bus.busy) begin ok = 1; break; end
        end
        chk({name, "_done"}, 32'(ok), 32'd1);
        chk({name, "_leftover"}, 32'(exp_q.size()), 32'd0);
        clear_stim();
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_pushin"}, 32'(bus.enc_pushin), 32'd0);
        chk({name, "_datain"}, 32'(bus.enc_datain), 32'd0);
        chk({name, "_startin"}, 32'(bus.enc_startin), 32'd0);
        chk({name, "_grant"}, 32'(bus.grant_id), 32'd0);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_trunc"}, 32'(bus.trunc_err), 32'd0);
        chk({name, "_ready"}, 32'(bus.req_ready), 32'd0);
    endtask

    task automatic do_reset(input string name);
        @(posedge clk); #2;
        mon_en = 0;
        clear_stim();
        reset_n = 1'b0;
        #1 check_reset_outputs(name);
        m_rr = 0; have_eop = 0; idle_cnt = 0; last_sym = '0; dcnt = 0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs({name, "_hold"});
        @(negedge clk) reset_n = 1'b1;
    endtask

    task automatic add_rand_pkt(input int r, input int len);
        for (int b = 0; b < len; b++) stim_q[r].push_back({b == len - 1, 8'($urandom)});
    endtask

    initial begin
        bit ok;
        #1 check_reset_outputs("por");
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        // single 3-byte packet on req0
        stim_q[0].push_back(9'h011);
        stim_q[0].push_back(9'h022);
        stim_q[0].push_back(9'h133);
        run_phase("single");

        // 1-byte packets from every requester: order 0,1,2,3,0 with exact gaps
        do_reset("rst_b");
        stim_q[0].push_back(9'h1A0);
        stim_q[0].push_back(9'h1A4);
        stim_q[1].push_back(9'h1A1);
        stim_q[2].push_back(9'h1A2);
        stim_q[3].push_back(9'h1A3);
        run_phase("rr");

        // truncation: 7 bytes with MAX_LEN=4, requester 3 waiting behind with a held byte
        for (int b = 1; b <= 7; b++) stim_q[2].push_back({b == 7, 8'(8'hB0 + b)});
        add_rand_pkt(3, 2);
        run_phase("trunc");

        // randomized mixed traffic from all requesters
        for (int r = 0; r < NR; r++)
            for (int p = 0; p < 4; p++) add_rand_pkt(r, $urandom_range(1, 7));
        run_phase("random");

        // reset in the middle of DATA, then rr must restart at requester 0
        add_rand_pkt(1, 6);
        dcnt = 0;
        start_drivers();
        ok = 0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            if (dcnt >= 2) begin ok = 1; break; end
        end
        chk("mid_data_reached", 32'(ok), 32'd1);
        chk("mid_data_busy", 32'(bus.busy), 32'd1);
        mon_en = 0;
        clear_stim();
        reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        m_rr = 0; have_eop = 0; idle_cnt = 0; last_sym = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        add_rand_pkt(2, 3);
        add_rand_pkt(0, 2);
        run_phase("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
